// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for serial datapath controllers: FSM encodings and default width.
package serial_addsub_ctrl_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle between a requesting unit (master) and the serial add/sub controller (slave).
interface serial_addsub_ctrl_if
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub_ctrl_fa.sv
// One-bit adder cell shared by serial datapaths: full_adder built from two half_adders.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: feeds one full_adder LSB-first over WIDTH cycles.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_addsub_ctrl_if.slave  bus
);
  localparam int            CNT_W = $clog2(WIDTH);
  localparam int            ACC_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               cy_q, cy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;

  logic fa_s, fa_co;

  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .ci(cy_q), .s(fa_s), .co(fa_co));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cy_d        = cy_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          // Subtract is A + ~B + 1: invert B and seed the carry with sub.
          state_d = ST_RUN;
          a_d     = bus.op_a;
          b_d     = bus.op_b ^ {WIDTH{bus.sub}};
          cy_d    = bus.sub;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_co;
        acc_d = ACC_W'({fa_s, acc_q} >> 1);
        if (cnt_q == LAST) begin
          // cy_q is the carry into the MSB, fa_co the carry out of it.
          state_d     = ST_DONE;
          result_d    = {fa_s, acc_q};
          carry_out_d = fa_co;
          overflow_d  = cy_q ^ fa_co;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cy_q        <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cy_q        <= cy_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: directed table, handshake/reset sequences, random ops vs arithmetic model.
module tb_serial_addsub_ctrl;
  localparam int W   = 8;
  localparam int LIM = 3 * W;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned carry/borrow and signed range test.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] r, output logic co, output logic ov);
    int ua, ub, sa, sb, ss;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = W'(ua - ub);
      co = (ua >= ub);
      ss = sa - sb;
    end else begin
      r  = W'(ua + ub);
      co = (ua + ub) >= (1 << W);
      ss = sa + sb;
    end
    ov = (ss > ((1 << (W - 1)) - 1)) || (ss < -(1 << (W - 1)));
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] er, input logic eco, input logic eov, input string tag);
    int n;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = sub;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk); #1;
    check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    busy_cnt = int'(bus.busy);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.sub   = 1'($urandom);
    n = 0;
    while (n < LIM) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
      busy_cnt += int'(bus.busy);
    end
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_carry"}, 32'(bus.carry_out), 32'(eco));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(eov));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {bus.done, bus.busy}, 32'd0);
    check({tag, "_result_held"}, 32'(bus.result), 32'(er));
  endtask

  vec_t vecs[5];

  initial begin
    logic [W-1:0] ra, rb, er;
    logic rs, eco, eov;
    int n;
    int done_seen;
    tests = 0;
    fails = 0;
    vecs[0] = '{a: 8'h3C, b: 8'h0F, sub: 1'b0, res: 8'h4B, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h05, b: 8'h07, sub: 1'b1, res: 8'hFE, co: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h07, b: 8'h05, sub: 1'b1, res: 8'h02, co: 1'b1, ov: 1'b0};

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {bus.busy, bus.done, bus.carry_out, bus.overflow, bus.result}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].co, vecs[i].ov,
            $sformatf("vec%0d", i));

    // Start while busy is ignored; start in DONE is accepted back-to-back.
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.op_a = 8'h3C; bus.op_b = 8'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h01; bus.op_b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0; bus.op_a = 8'hAA; bus.op_b = 8'h55;
    n = 3;
    while (n < LIM) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
    end
    check("hs_ignored_latency", 32'(n), 32'(W));
    check("hs_ignored_result", 32'(bus.result), 32'h4B);
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h01; bus.op_b = 8'h01; bus.sub = 1'b0;
    @(posedge clk); #1;
    check("b2b_accepted", {bus.busy, bus.done}, 32'b10);
    check("b2b_result_kept", 32'(bus.result), 32'h4B);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (n < LIM) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
    end
    check("b2b_latency", 32'(n), 32'(W));
    check("b2b_result", 32'(bus.result), 32'h02);

    // Reset mid-RUN, asserted together with start: abort, no done.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h12; bus.op_b = 8'h34;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs", {bus.busy, bus.done, bus.carry_out, bus.overflow, bus.result}, 32'd0);
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    done_seen = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      done_seen += int'(bus.done) + int'(bus.busy);
    end
    check("rst_mid_no_done", 32'(done_seen), 32'd0);
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "after_rst");

    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, er, eco, eov);
      do_op(ra, rb, rs, er, eco, eov, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
